sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's fixed 16-bit × 64 FIFO.
- Adds configurable width and depth, a registered read port with a valid strobe, an occupancy count, and programmable almost-full/almost-empty flags.
- Sits between producer and consumer blocks in the same clock domain; used as a rate-matching buffer.

Parameters:
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 64, number of entries; power of two, ≥2.
- AF_THRESH, DEPTH-4, almost_full asserts when count ≥ AF_THRESH (1..DEPTH).
- AE_THRESH, 4, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wdata  in  WIDTH  write data.
- wen  in  1  write request.
- full  out  1  FIFO holds DEPTH entries.
- almost_full  out  1  count ≥ AF_THRESH.
- rdata  out  WIDTH  read data, registered.
- rvalid  out  1  rdata holds a word popped on the previous cycle.
- ren  in  1  read request.
- empty  out  1  FIFO holds 0 entries.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Pointers: waddr and raddr are AW+1 bits, where AW = $clog2(DEPTH). The low AW bits index storage; the MSB is a wrap bit. Pointers wrap naturally modulo 2·DEPTH.
- empty = (waddr == raddr).
- full = low bits equal AND MSBs differ.
- count = waddr − raddr, modulo 2^(AW+1).
- full, empty, count, almost_full and almost_empty are combinational from the registered pointers only, with no path from wen or ren.
- Write accept: wvalid = wen & ~full. On accept, mem[waddr[AW-1:0]] <= wdata and waddr increments.
- Read accept: rvalid_int = ren & ~empty. On accept, rdata <= mem[raddr[AW-1:0]] and raddr increments. rvalid is registered rvalid_int, so latency is 1 cycle from accepted ren to rdata/rvalid.
- rdata holds its last value when no read is accepted. rvalid is high for exactly one cycle per accepted read.
- Simultaneous wen and ren, neither full nor empty: both accepted; count unchanged.
- Simultaneous wen and ren while empty: only the write is accepted. The read is ignored (no bypass); rvalid stays 0 next cycle.
- Simultaneous wen and ren while full: only the read is accepted. The write is dropped; count becomes DEPTH-1.
- Write while full, or read while empty: ignored, with no state change.
- Reset values: waddr=0, raddr=0, rdata=0, rvalid=0. Hence empty=1, full=0, count=0, almost_empty=1, almost_full=0. Storage is not reset.
- Reset asserted mid-operation: pointers and outputs go to reset values immediately (asynchronously). Buffered contents are discarded. An rvalid due in the following cycle is suppressed.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- Defined: adds ports overflow (out, 1), underflow (out, 1) and err_clr (in, 1).
  - overflow sets sticky on wen & full; underflow sets sticky on ren & empty.
  - Both clear on err_clr or rst. If err_clr and a set event coincide, the set wins.
  - Both reset to 0.
- Not defined: these ports and registers do not exist. Overflow and underflow attempts are silently ignored, as described above.

Decomposition:
- Package sync_fifo_pkg holds:
  - localparam helper function for AW;
  - default WIDTH/DEPTH constants;
  - count type width rule.
- One sub-module, sync_fifo_mem: simple dual-port array with one write port and one registered read port (we, waddr, wdata, re, raddr, rdata). No reset on the array; rdata register reset by rst.
- Pointer, flag and error logic stay in the top module.

Test Plan:
- Reset/idle: assert rst mid-stream after 5 writes → empty=1, count=0, rvalid=0, rdata=0 immediately. After release, a read returns nothing (rvalid=0).
- Fill/drain, DEPTH=8, WIDTH=16: write 0x0001..0x0008 → full=1, count=8. A 9th write of 0xDEAD is dropped. Then 8 reads → rdata 0x0001..0x0008 in order, each 1 cycle after its ren, and empty=1.
- Thresholds, DEPTH=8, AF_THRESH=6, AE_THRESH=2: count 2→3 deasserts almost_empty; count 5→6 asserts almost_full. Both flags change in the same cycle as count.
- Simultaneous ops:
  - At count=4, wen&ren for 10 cycles → count stays 4; output order preserved.
  - While empty, wen&ren → count=1, rvalid=0.
  - While full, wen&ren → count=7.
- Wrap-around, DEPTH=4: 20 cycles of streaming with random wen/ren → scoreboard matches and count never exceeds 4. Pointer MSB toggles at least twice.
- SYNC_FIFO_ERR_EN: write while full → overflow=1 and stays set. Read while empty → underflow=1. err_clr pulse → both 0. err_clr coinciding with wen&full → overflow=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 64;

    // Storage index width; a depth of 1 would still need a 1-bit index.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Occupancy spans 0..DEPTH, so it needs one bit beyond the index.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned NUM = 1 << AW;

    logic [WIDTH-1:0] r_mem [NUM];
    logic [WIDTH-1:0] r_rdata;

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with registered read, count and threshold flags.
// Optional sticky overflow/underflow flags when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      wen,
    output logic                      full,
    output logic                      almost_full,
    output logic [WIDTH-1:0]          rdata,
    output logic                      rvalid,
    input  logic                      ren,
    output logic                      empty,
    output logic                      almost_empty,
`ifdef SYNC_FIFO_ERR_EN
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      err_clr,
`endif
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [AW:0]   r_waddr;
    logic [AW:0]   r_raddr;
    logic          r_rvalid;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_wvalid;
    logic          w_rvalid_int;

    // Status depends only on the registered pointers.
    assign w_empty = (r_waddr == r_raddr);
    assign w_full  = (r_waddr[AW-1:0] == r_raddr[AW-1:0]) && (r_waddr[AW] != r_raddr[AW]);
    assign w_count = CW'(r_waddr - r_raddr);

    assign w_wvalid     = wen & ~w_full;
    assign w_rvalid_int = ren & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr  <= '0;
            r_raddr  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wvalid) begin
                r_waddr <= r_waddr + (AW+1)'(1);
            end
            if (w_rvalid_int) begin
                r_raddr <= r_raddr + (AW+1)'(1);
            end
            r_rvalid <= w_rvalid_int;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wvalid),
        .waddr (r_waddr[AW-1:0]),
        .wdata (wdata),
        .re    (w_rvalid_int),
        .raddr (r_raddr[AW-1:0]),
        .rdata (rdata)
    );

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= CW'(AF_THRESH));
    assign almost_empty = (w_count <= CW'(AE_THRESH));
    assign rvalid       = r_rvalid;

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wen & w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (ren & w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and random bench for sync_fifo_param using a queue scoreboard.
// Builds with or without SYNC_FIFO_ERR_EN.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-deep instance
    logic [15:0] wd8 = '0, rd8;
    logic        we8 = 1'b0, re8 = 1'b0;
    logic        full8, af8, rv8, em8, ae8;
    logic [3:0]  cnt8;
    // 4-deep instance for wrap-around streaming
    logic [15:0] wd4 = '0, rd4;
    logic        we4 = 1'b0, re4 = 1'b0;
    logic        full4, af4, rv4, em4, ae4;
    logic [2:0]  cnt4;
`ifdef SYNC_FIFO_ERR_EN
    logic        ov8, un8, ov4, un4;
    logic        clr8 = 1'b0;
    logic        clr4 = 1'b0;
`endif

    sync_fifo_param #(.WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut8 (
        .clk(clk), .rst(rst), .wdata(wd8), .wen(we8), .full(full8),
        .almost_full(af8), .rdata(rd8), .rvalid(rv8), .ren(re8), .empty(em8),
        .almost_empty(ae8),
`ifdef SYNC_FIFO_ERR_EN
        .overflow(ov8), .underflow(un8), .err_clr(clr8),
`endif
        .count(cnt8)
    );

    sync_fifo_param #(.WIDTH(16), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut4 (
        .clk(clk), .rst(rst), .wdata(wd4), .wen(we4), .full(full4),
        .almost_full(af4), .rdata(rd4), .rvalid(rv4), .ren(re4), .empty(em4),
        .almost_empty(ae4),
`ifdef SYNC_FIFO_ERR_EN
        .overflow(ov4), .underflow(un4), .err_clr(clr4),
`endif
        .count(cnt4)
    );

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [15:0] mq[$];
    int          mcnt = 0;
    logic [15:0] mrd = '0;
    bit          mov = 1'b0, mun = 1'b0;
    bit          tb_clr = 1'b0;
    int          nw = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the chosen instance, then full model check.
    task automatic cyc(input bit sel, input bit we, input logic [15:0] wd, input bit re);
        int d, af, ae;
        bit wacc, racc, ov_ev, un_ev;
        d     = sel ? 4 : 8;
        af    = sel ? 3 : 6;
        ae    = sel ? 1 : 2;
        wacc  = we && (mcnt < d);
        racc  = re && (mcnt > 0);
        ov_ev = we && (mcnt == d);
        un_ev = re && (mcnt == 0);
        if (sel) begin
            we4 = we; wd4 = wd; re4 = re;
        end else begin
            we8 = we; wd8 = wd; re8 = re;
`ifdef SYNC_FIFO_ERR_EN
            clr8 = tb_clr;
`endif
        end
        @(posedge clk); #1;
        we4 = 1'b0; re4 = 1'b0; we8 = 1'b0; re8 = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        clr8 = 1'b0;
`endif
        if (racc) mrd = mq.pop_front();
        if (wacc) mq.push_back(wd);
        mcnt = mcnt + int'(wacc) - int'(racc);
        if (ov_ev) mov = 1'b1; else if (tb_clr) mov = 1'b0;
        if (un_ev) mun = 1'b1; else if (tb_clr) mun = 1'b0;
        tb_clr = 1'b0;
        chk("rvalid", 32'(sel ? rv4 : rv8), 32'(racc));
        chk("rdata",  32'(sel ? rd4 : rd8), 32'(mrd));
        chk("count",  sel ? 32'(cnt4) : 32'(cnt8), 32'(mcnt));
        chk("empty",  32'(sel ? em4 : em8), 32'(mcnt == 0));
        chk("full",   32'(sel ? full4 : full8), 32'(mcnt == d));
        chk("almost_empty", 32'(sel ? ae4 : ae8), 32'(mcnt <= ae));
        chk("almost_full",  32'(sel ? af4 : af8), 32'(mcnt >= af));
`ifdef SYNC_FIFO_ERR_EN
        if (!sel) begin
            chk("overflow",  32'(ov8), 32'(mov));
            chk("underflow", 32'(un8), 32'(mun));
        end
`endif
    endtask

    task automatic model_reset();
        mq.delete();
        mcnt = 0; mrd = '0; mov = 1'b0; mun = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_empty", 32'(em8), 32'd1);
        chk("rst_full",  32'(full8), 32'd0);
        chk("rst_count", 32'(cnt8), 32'd0);
        chk("rst_ae",    32'(ae8), 32'd1);
        chk("rst_af",    32'(af8), 32'd0);
        chk("rst_rvalid", 32'(rv8), 32'd0);
        chk("rst_rdata", 32'(rd8), 32'd0);

        // Reset mid-stream: 5 writes, one read, then async reset with a read pending
        for (int i = 1; i <= 5; i++) cyc(0, 1'b1, 16'(i), 1'b0);
        cyc(0, 1'b0, 16'h0, 1'b1);
        re8 = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_empty",  32'(em8), 32'd1);
        chk("arst_count",  32'(cnt8), 32'd0);
        chk("arst_rvalid", 32'(rv8), 32'd0);
        chk("arst_rdata",  32'(rd8), 32'd0);
        @(posedge clk); #1;
        chk("arst_rvalid_next", 32'(rv8), 32'd0);
        re8 = 1'b0;
        rst = 1'b0;
        cyc(0, 1'b0, 16'h0, 1'b1);

        // Fill to full, dropped write, read+write while full, drain
        for (int i = 1; i <= 8; i++) cyc(0, 1'b1, 16'(i), 1'b0);
        cyc(0, 1'b1, 16'hDEAD, 1'b0);
        cyc(0, 1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 7; i++) cyc(0, 1'b0, 16'h0, 1'b1);
        cyc(0, 1'b0, 16'h0, 1'b1);

        // Threshold walk up to 6, back to 4, then 10 simultaneous cycles
        for (int i = 0; i < 6; i++) cyc(0, 1'b1, 16'(16'h0020 + i), 1'b0);
        for (int i = 0; i < 2; i++) cyc(0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(0, 1'b1, 16'(16'h0100 + i), 1'b1);
        while (mcnt > 0) cyc(0, 1'b0, 16'h0, 1'b1);

        // Simultaneous while empty: write only
        cyc(0, 1'b1, 16'h0055, 1'b1);
        cyc(0, 1'b0, 16'h0, 1'b1);

`ifdef SYNC_FIFO_ERR_EN
        for (int i = 0; i < 8; i++) cyc(0, 1'b1, 16'(16'h0200 + i), 1'b0);
        cyc(0, 1'b1, 16'hDEAD, 1'b0);
        cyc(0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(0, 1'b0, 16'h0, 1'b1);
        cyc(0, 1'b0, 16'h0, 1'b1);
        tb_clr = 1'b1;
        cyc(0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(0, 1'b1, 16'(16'h0300 + i), 1'b0);
        tb_clr = 1'b1;
        cyc(0, 1'b1, 16'hDEAD, 1'b0);
        while (mcnt > 0) cyc(0, 1'b0, 16'h0, 1'b1);
`endif

        // Random streaming on the 4-deep instance until pointers wrap twice
        model_reset();
        nw = 0;
        for (int i = 0; i < 200 && (i < 20 || nw < 8); i++) begin
            bit w, r;
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if (w && mcnt < 4) nw++;
            cyc(1, w, 16'($urandom_range(0, 16'hFFFF)), r);
            chk("cnt_le_depth", 32'(cnt4 <= 3'd4), 32'd1);
        end
        chk("wrap_writes", 32'(nw >= 8), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
